// File: rtl/countdown_timer.sv
// countdown_timer: a loadable down-counter with an expiry pulse and optional auto-reload.
// The processor control FSM uses it for its wait/delay states, and it can also serve as
// a periodic tick source. A count is live only in RUN, so the count never has to wrap
// below zero.

module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CountZero = '0;
    localparam logic [WIDTH-1:0] CountOne  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // Next-state logic. The priority order is load, then terminal/decrement, then hold.
    // A load always wins over a same-cycle expiry, so a restart never emits a done pulse.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = (load_val_i != CountZero) ? RUN : IDLE;
        end else if ((state_q == RUN) && en_i) begin
            if (count_q == CountOne) begin
                done_d = 1'b1;
                if (auto_reload_i) begin
                    count_d = reload_q;
                end else begin
                    count_d = CountZero;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - CountOne;
            end
        end
    end

    // State registers. A synchronous reset aborts any countdown and clears the reload value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= CountZero;
            reload_q <= CountZero;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign out_o  = count_q;
    assign zero_o = (count_q == CountZero);
    assign done_o = done_q;
    assign busy_o = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer. The stimulus process drives one vector per cycle and
// queues the outputs expected after that clock edge. The monitor process checks those
// expected outputs shortly after each rising edge.

module tb_countdown_timer;

    localparam int WIDTH = 4;

    typedef struct {
        int               step;
        logic [WIDTH-1:0] out;
        logic             zero;
        logic             done;
        logic             busy;
    } expect_t;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic             en;
    logic             autoReload;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             done;
    logic             busy;

    expect_t expQ[$];
    int      checks;
    int      errors;
    int      stepNum;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load),
        .load_val_i   (loadVal),
        .en_i         (en),
        .auto_reload_i(autoReload),
        .out_o        (out),
        .zero_o       (zero),
        .done_o       (done),
        .busy_o       (busy)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one field; any mismatch prints a FAIL line and is counted.
    task automatic checkField(input string name, input int step, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, step, actual, required);
        end
    endtask

    // Check every output against one queued expectation.
    task automatic checkOutput(input expect_t e);
        checkField("out",  e.step, int'(out),  int'(e.out));
        checkField("zero", e.step, int'(zero), int'(e.zero));
        checkField("done", e.step, int'(done), int'(e.done));
        checkField("busy", e.step, int'(busy), int'(e.busy));
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after
    // the next rising edge.
    task automatic applyStimulus(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                                 input logic e, input logic ar,
                                 input logic [WIDTH-1:0] eOut, input logic eZero,
                                 input logic eDone, input logic eBusy);
        expect_t x;
        @(negedge clk);
        rst        = r;
        load       = ld;
        loadVal    = lv;
        en         = e;
        autoReload = ar;
        stepNum++;
        x.step = stepNum;
        x.out  = eOut;
        x.zero = eZero;
        x.done = eDone;
        x.busy = eBusy;
        expQ.push_back(x);
    endtask

    // Monitor: check the outputs 1 ns after each rising edge, away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Directed stimulus with hand-computed expected outputs.
    initial begin
        int waitCycles;
        checks = 0; errors = 0; stepNum = 0;
        rst = 1'b1; load = 1'b0; loadVal = '0; en = 1'b0; autoReload = 1'b0;

        // Reset has priority over a pending load; afterwards the timer stays idle and ignores en.
        applyStimulus(1, 1, 9, 0, 0,  0, 1, 0, 0);
        applyStimulus(1, 1, 9, 0, 0,  0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 0, 0);

        // Basic countdown from 3: out goes 3, 2, 1, 0, and done/zero rise while busy falls.
        applyStimulus(0, 1, 3, 1, 0,  3, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  2, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 0, 0);

        // Enable gating: out goes 2, 1, 1, 1, 0, with a single done pulse at the end.
        applyStimulus(0, 1, 2, 0, 0,  2, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 1, 0);

        // Auto-reload from 2 for 8 enabled cycles: zero never rises and busy stays high.
        applyStimulus(0, 1, 2, 0, 1,  2, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 1,  1, 0, 0, 1);
            applyStimulus(0, 0, 0, 1, 1,  2, 0, 1, 1);
        end
        // Loading 0 in RUN stops the timer without a done pulse.
        applyStimulus(0, 1, 0, 1, 1,  0, 1, 0, 0);

        // A load in the terminal cycle wins: no done, and the count restarts from 5.
        applyStimulus(0, 1, 1, 0, 0,  1, 0, 0, 1);
        applyStimulus(0, 1, 5, 1, 0,  5, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  4, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 0,  0, 1, 0, 0);

        // auto_reload only matters in the terminal cycle.
        applyStimulus(0, 1, 3, 0, 1,  3, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  2, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0,  0, 1, 1, 0);

        // Back-to-back expiries with a reload value of 1 give done on every cycle.
        applyStimulus(0, 1, 1, 0, 1,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1,  1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1,  1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1,  1, 0, 1, 1);

        // Reset mid-count at out=9 aborts the count, and the reload register is cleared.
        applyStimulus(0, 1, 15, 1, 1, 15, 0, 0, 1);
        for (int v = 14; v >= 9; v--) begin
            applyStimulus(0, 0, 0, 1, 1,  WIDTH'(v), 0, 0, 1);
        end
        applyStimulus(1, 0, 0, 1, 1,  0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1,  0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 1,  1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1,  1, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1,  1, 0, 1, 1);

        // Reset in a terminal cycle suppresses the done pulse.
        applyStimulus(0, 1, 1, 0, 0,  1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0,  0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0,  0, 1, 0, 0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
